// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle CPU datapath: sequences fetch, decode, execute,
// memory access and write-back, and drives the datapath strobes and selects.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  FETCH     | read instruction at PC, PC+1 into PC once memory is ready
//  DECODE    | branch target into ALUOut, opcode latched for later states
//  EXEC_R    | register-register ALU operation selected by Funct
//  EXEC_I    | register + sign-extended immediate
//  WB_R      | ALUOut into register file
//  MEM_ADDR  | effective address = A + immediate
//  MEM_READ  | data read, waits for MemReady
//  MEM_WB    | memory data into register file
//  MEM_WRITE | data write, waits for MemReady
//  BRANCH    | conditional PC load from ALUOut on Zero
//  JUMP      | unconditional PC load from jump target
//  HALT      | parked until reset
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Opcode,
  input  logic [2:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       Halted,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    WB_R      = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    HALT      = 4'd11
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_JUMP  = 3'b101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_PASS_A = 3'b101;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] op_q;
  logic [2:0] op_nxt;

  // Opcode is captured on leaving DECODE so MEM_ADDR never sees a changing IR.
  assign op_nxt = (state == DECODE) ? Opcode : op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      op_q  <= OP_RTYPE;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PC_ALU;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    Halted     = 1'b0;
    StateOut   = state;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_RTYPE:          state_nxt = EXEC_R;
          OP_ADDI:           state_nxt = EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = MEM_ADDR;
          OP_BEQ:            state_nxt = BRANCH;
          OP_JUMP:           state_nxt = JUMP;
          default:           state_nxt = HALT;
        endcase
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = Funct;
        state_nxt  = WB_R;
      end
      EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = WB_R;
      end
      WB_R: begin
        RegWrite  = 1'b1;
        state_nxt = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op_q == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_nxt = MEM_WB;
      end
      MEM_WB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        state_nxt = FETCH;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_PASS_A;
        PCSrc      = PC_ALUOUT;
        PCWrite    = Zero;
        state_nxt  = FETCH;
      end
      JUMP: begin
        PCSrc     = PC_JUMP;
        PCWrite   = 1'b1;
        state_nxt = FETCH;
      end
      HALT: begin
        Halted    = 1'b1;
        state_nxt = HALT;
      end
      default: begin
        StateOut  = 4'd0;
        state_nxt = FETCH;
      end
    endcase

    // Reset forces a quiet bus so no write strobe can coincide with rst.
    if (rst) begin
      ALUControl = ALU_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      PCSrc      = PC_ALU;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = 1'b0;
      Halted     = 1'b0;
      StateOut   = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level reference model pushes per-cycle expected
// outputs; a negedge monitor pops and compares against the controller.
module tb_multicycle_controller;

  logic       clk = 1'b1;
  logic       rst;
  logic [2:0] Opcode;
  logic [2:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemToReg, Halted;
  logic [3:0] StateOut;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .Halted(Halted), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rw;
    logic       m2r;
    logic       halt;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Expected outputs for a state code, straight from the per-state output table.
  function automatic obs_t spec_out(input int st, input bit mrdy, input bit z, input logic [2:0] f);
    obs_t o;
    o = '0;
    o.st = st[3:0];
    case (st)
      0:  begin o.mrd = 1; o.srcb = 2'b01; o.pcw = mrdy; o.irw = mrdy; end
      1:  o.srcb = 2'b10;
      2:  begin o.srca = 1; o.alu = f; end
      3:  begin o.srca = 1; o.srcb = 2'b10; end
      4:  o.rw = 1;
      5:  begin o.srca = 1; o.srcb = 2'b10; end
      6:  begin o.mrd = 1; o.iord = 1; end
      7:  begin o.rw = 1; o.m2r = 1; end
      8:  begin o.mwr = 1; o.iord = 1; end
      9:  begin o.srca = 1; o.alu = 3'b101; o.pcsrc = 2'b01; o.pcw = z; end
      10: begin o.pcsrc = 2'b10; o.pcw = 1; end
      11: o.halt = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic step(input logic r, input logic [2:0] op, input logic mr, input logic z, input obs_t e);
    rst = r; Opcode = op; MemReady = mr; Zero = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int st, input logic [2:0] op, input logic mr, input logic z);
    step(1'b0, op, mr, z, spec_out(st, mr, z, Funct));
  endtask

  task automatic rst_step();
    step(1'b1, rop(), rb(), rb(), '0);
  endtask

  // One instruction: fs fetch stalls, ms memory stalls, zb = Zero in BRANCH,
  // hc cycles observed in HALT, abort = reset while a store is still waiting.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] f, input int fs,
                           input int ms, input logic zb, input int hc, input bit abort);
    Funct = f;
    for (int i = 0; i < fs; i++) cyc(0, rop(), 1'b0, rb());
    cyc(0, rop(), 1'b1, rb());
    cyc(1, op, rb(), rb());
    case (op)
      3'd0: begin cyc(2, rop(), rb(), rb()); cyc(4, rop(), rb(), rb()); end
      3'd1: begin cyc(3, rop(), rb(), rb()); cyc(4, rop(), rb(), rb()); end
      3'd2: begin
        cyc(5, rop(), rb(), rb());
        for (int i = 0; i < ms; i++) cyc(6, rop(), 1'b0, rb());
        cyc(6, rop(), 1'b1, rb());
        cyc(7, rop(), rb(), rb());
      end
      3'd3: begin
        cyc(5, rop(), rb(), rb());
        for (int i = 0; i < ms; i++) cyc(8, rop(), 1'b0, rb());
        if (abort) rst_step();
        else cyc(8, rop(), 1'b1, rb());
      end
      3'd4: cyc(9, rop(), rb(), zb);
      3'd5: cyc(10, rop(), rb(), rb());
      default: begin
        for (int i = 0; i < hc; i++) cyc(11, rop(), rb(), rb());
        rst_step();
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {StateOut, ALUControl, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite,
               MemRead, MemWrite, IorD, RegWrite, MemToReg, Halted};
      n_chk++;
      if (mon_a === mon_e) n_pass++;
      else $display("FAIL cycle_outputs t=%0t state got=%0d exp=%0d vector got=%h exp=%h",
                    $time, mon_a.st, mon_e.st, mon_a, mon_e);
    end
  end

  initial begin
    Funct = 3'b000;
    rst_step();
    rst_step();
    run_instr(3'b000, 3'b011, 0, 0, 1'b0, 0, 1'b0);
    run_instr(3'b000, 3'b111, 0, 0, 1'b0, 0, 1'b0);
    run_instr(3'b010, 3'b000, 0, 2, 1'b0, 0, 1'b0);
    run_instr(3'b100, 3'b000, 0, 0, 1'b1, 0, 1'b0);
    run_instr(3'b100, 3'b000, 0, 0, 1'b0, 0, 1'b0);
    run_instr(3'b001, 3'b000, 3, 0, 1'b0, 0, 1'b0);
    run_instr(3'b011, 3'b000, 0, 1, 1'b0, 0, 1'b0);
    run_instr(3'b101, 3'b000, 0, 0, 1'b0, 0, 1'b0);
    run_instr(3'b111, 3'b000, 0, 0, 1'b0, 10, 1'b0);
    run_instr(3'b011, 3'b000, 0, 2, 1'b0, 0, 1'b1);
    run_instr(3'b110, 3'b000, 1, 0, 1'b0, 3, 1'b0);
    for (int n = 0; n < 200; n++) begin
      logic [2:0] op;
      int ms;
      bit ab;
      op = rop();
      ms = $urandom_range(0, 3);
      ab = (op == 3'b011) && (ms > 0) && ($urandom_range(0, 3) == 0);
      run_instr(op, rop(), $urandom_range(0, 2), ms, rb(), $urandom_range(1, 5), ab);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain pending got=%0d exp=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset (polarity and synchronicity fixed).
REQ-002: clk  in  1  rising-edge clock for all state.
REQ-003: rst  in  1  synchronous active-high reset, sampled at posedge clk.
REQ-004: Opcode  in  3  IR[15:13], valid from DECODE onward.
REQ-005: Funct  in  3  IR[2:0], the R-type ALU operation.
REQ-006: Zero  in  1  ALU zero flag, same cycle as ALUControl.
REQ-007: MemReady  in  1  memory completes the current read or write this cycle.
REQ-008: ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 not In1, 101 pass In1, 110 pass In2.
REQ-009: ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-010: ALUSrcB  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate.
REQ-011: PCSrc  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012: PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemToReg  out  1 each  datapath strobes and selects.
REQ-013: Halted  out  1  high while in HALT.
REQ-014: StateOut  out  4  current state code, for debug and verification.

Function
REQ-015: The block SHALL be a single FSM with these codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_R 4, MEM_ADDR 5, MEM_READ 6, MEM_WB 7, MEM_WRITE 8, BRANCH 9, JUMP 10, HALT 11.
REQ-016: Outputs SHALL be combinational from state, plus MemReady or Zero where stated; any output not listed for a state SHALL be 0.
REQ-017: Codes 12-15 SHALL be unreachable and SHALL transition to FETCH with all outputs 0.
REQ-018: FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=000, PCSrc=00.
  - When MemReady=1: IRWrite=1, PCWrite=1, next state DECODE.
  - Otherwise: IRWrite=0, PCWrite=0, and the FSM stays in FETCH.
REQ-019: DECODE: ALUSrcA=0, ALUSrcB=10, ALUControl=000 (branch target into ALUOut). Next state by Opcode:
  - 000 -> EXEC_R
  - 001 -> EXEC_I
  - 010 or 011 -> MEM_ADDR
  - 100 -> BRANCH
  - 101 -> JUMP
  - 110 or 111 -> HALT
REQ-020: EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl=Funct passed unaltered (111 included); next state WB_R.
REQ-021: EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUControl=000; next state WB_R.
REQ-022: WB_R: RegWrite=1, MemToReg=0; next state FETCH.
REQ-023: MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUControl=000. Next state is MEM_READ if the latched opcode is 010, MEM_WRITE if it is 011.
REQ-024: MEM_READ: MemRead=1, IorD=1. Stays until MemReady=1, then goes to MEM_WB.
REQ-025: MEM_WB: RegWrite=1, MemToReg=1; next state FETCH.
REQ-026: MEM_WRITE: MemWrite=1, IorD=1. Stays until MemReady=1, then goes to FETCH.
REQ-027: BRANCH: ALUSrcA=1, ALUControl=101, PCSrc=01, PCWrite=Zero; next state FETCH.
REQ-028: JUMP: PCSrc=10, PCWrite=1; next state FETCH.
REQ-029: HALT: Halted=1, all strobes 0; the FSM remains in HALT until rst.
REQ-030: The block SHALL register the opcode on the DECODE->next-state transition, so that MEM_ADDR's branch (REQ-023) does not depend on a changing Opcode input.
REQ-031: Cycle counts with MemReady tied to 1 SHALL be:
  - R-type and ADDI: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH and JUMP: 3
  Each MemReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
REQ-032: PCWrite, IRWrite, RegWrite and MemWrite SHALL never be asserted in the same cycle as rst=1.

Reset
REQ-033: On posedge clk with rst=1, state SHALL become FETCH and the latched opcode SHALL become 000. This applies from any state, including HALT and mid memory wait.
REQ-034: While rst=1, all outputs SHALL be 0, with ALUControl=000 and StateOut=0.
REQ-035: The first cycle after rst falls SHALL be FETCH with MemRead=1.

Verification
REQ-036: R-type: Opcode=000, Funct=011, MemReady=1. StateOut SHALL be 0,1,2,4,0. ALUControl=011 in EXEC_R. RegWrite=1 only in WB_R.
REQ-037: LOAD with stall: Opcode=010, MemReady=0 for 2 cycles in MEM_READ. StateOut SHALL be 0,1,5,6,6,6,7,0. MemToReg=1 in state 7.
REQ-038: Branch: Opcode=100.
  - With Zero=1: PCWrite=1, PCSrc=01 in BRANCH.
  - With Zero=0: PCWrite=0. Both cases return to FETCH.
REQ-039: Fetch stall: MemReady=0 for 3 cycles. IRWrite and PCWrite SHALL stay 0, then pulse once together.
REQ-040: Illegal opcode: Opcode=111 SHALL reach HALT (StateOut=11, Halted=1) and hold it for 10 cycles. A 1-cycle rst SHALL return StateOut=0.
REQ-041: Reset mid-STORE: rst asserted in MEM_WRITE with MemReady=0. The next state SHALL be FETCH with MemWrite=0.
